// File: rtl/vga_write_buffer.sv
// Circular write buffer between the processor's VGA store path and the
// framebuffer write port, which is only available while the scanner is blanking.
module vga_write_buffer #(
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 8,
  parameter int NUM_PIX = 307200
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     stall,
  input  logic                     fb_grant,
  output logic                     fb_we,
  output logic [ADDR_W-1:0]        fb_addr,
  output logic [DATA_W-1:0]        fb_data,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     overflow,
  output logic                     oob
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   PIX_LIMIT = (ADDR_W + 1)'(NUM_PIX);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic in_range;
  logic full;
  logic empty;
  logic push;
  logic pop;

  assign in_range = ({1'b0, wr_addr} < PIX_LIMIT);
  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  // Full/empty come from the registered count, so a same-edge pop cannot make room for a push.
  assign push     = wr_en && in_range && !full;
  assign pop      = fb_grant && !empty;

  assign stall   = full;
  assign pending = count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= wr_addr;
      mem_data[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      fb_we <= pop;
      if (pop) begin
        fb_addr <= mem_addr[rd_ptr];
        fb_data <= mem_data[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      oob      <= 1'b0;
    end else begin
      if (wr_en && !in_range)      oob      <= 1'b1;
      if (wr_en && in_range && full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_write_buffer.sv
// Directed bench for vga_write_buffer: reset, latency, fill/overflow, simultaneous
// push/pop, address range, pointer wrap under intermittent grant, and mid-run reset.
module tb_vga_write_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;
  logic        stall;
  logic        fb_grant;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [7:0]  fb_data;
  logic [3:0]  pending;
  logic        overflow;
  logic        oob;

  int n_pass  = 0;
  int n_total = 0;

  vga_write_buffer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .stall    (stall),
    .fb_grant (fb_grant),
    .fb_we    (fb_we),
    .fb_addr  (fb_addr),
    .fb_data  (fb_data),
    .pending  (pending),
    .overflow (overflow),
    .oob      (oob)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    fb_grant = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    fb_grant = 1'b0;
    #12;
    n_total++;
    if ({fb_we, stall, overflow, oob, pending} !== 8'h00)
      $display("FAIL reset_state: got we=%b stall=%b ovf=%b oob=%b pend=%0d, want all 0",
               fb_we, stall, overflow, oob, pending);
    else n_pass++;
    n_total++;
    if ({fb_addr, fb_data} !== 27'h0)
      $display("FAIL reset_fb_bus: got addr=%0d data=%h, want 0/00", fb_addr, fb_data);
    else n_pass++;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    wr_en = 1'b1; wr_addr = 19'd100; wr_data = 8'h3C; fb_grant = 1'b1;
    tick();
    wr_en = 1'b0;
    n_total++;
    if (fb_we !== 1'b0 || pending !== 4'd1)
      $display("FAIL single_edge1: got we=%b pend=%0d, want we=0 pend=1", fb_we, pending);
    else n_pass++;
    tick();
    n_total++;
    if (fb_we !== 1'b1 || fb_addr !== 19'd100 || fb_data !== 8'h3C || pending !== 4'd0)
      $display("FAIL single_edge2: got we=%b addr=%0d data=%h pend=%0d, want 1/100/3c/0",
               fb_we, fb_addr, fb_data, pending);
    else n_pass++;
    tick();
    fb_grant = 1'b0;
    n_total++;
    if (fb_we !== 1'b0 || fb_addr !== 19'd100 || fb_data !== 8'h3C)
      $display("FAIL single_after: got we=%b addr=%0d data=%h, want 0/100/3c", fb_we, fb_addr, fb_data);
    else n_pass++;
  endtask

  task automatic test_fill_overflow();
    fb_grant = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 19'(i); wr_data = 8'(8'h10 + i);
      tick();
    end
    n_total++;
    if (pending !== 4'd8 || stall !== 1'b1)
      $display("FAIL fill_full: got pend=%0d stall=%b, want 8/1", pending, stall);
    else n_pass++;
    wr_addr = 19'd50; wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    n_total++;
    if (pending !== 4'd8 || overflow !== 1'b1)
      $display("FAIL fill_drop: got pend=%0d ovf=%b, want 8/1", pending, overflow);
    else n_pass++;
    fb_grant = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_total++;
      if (fb_we !== 1'b1 || fb_addr !== 19'(i) || fb_data !== 8'(8'h10 + i))
        $display("FAIL fill_pop%0d: got we=%b addr=%0d data=%h, want 1/%0d/%h",
                 i, fb_we, fb_addr, fb_data, i, 8'(8'h10 + i));
      else n_pass++;
      if (i == 0) begin
        n_total++;
        if (stall !== 1'b0 || pending !== 4'd7)
          $display("FAIL fill_stall_fall: got stall=%b pend=%0d, want 0/7", stall, pending);
        else n_pass++;
      end
    end
    tick();
    fb_grant = 1'b0;
    n_total++;
    if (fb_we !== 1'b0 || pending !== 4'd0 || overflow !== 1'b1)
      $display("FAIL fill_drained: got we=%b pend=%0d ovf=%b, want 0/0/1", fb_we, pending, overflow);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    fb_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_addr = 19'(200 + i); wr_data = 8'(8'hA0 + i);
      tick();
    end
    n_total++;
    if (pending !== 4'd3)
      $display("FAIL simul_setup: got pend=%0d, want 3", pending);
    else n_pass++;
    wr_addr = 19'd203; wr_data = 8'hA3; fb_grant = 1'b1;
    tick();
    wr_en = 1'b0;
    n_total++;
    if (pending !== 4'd3 || fb_we !== 1'b1 || fb_addr !== 19'd200 || fb_data !== 8'hA0)
      $display("FAIL simul_pushpop: got pend=%0d we=%b addr=%0d data=%h, want 3/1/200/a0",
               pending, fb_we, fb_addr, fb_data);
    else n_pass++;
    for (int i = 1; i < 4; i++) begin
      tick();
      n_total++;
      if (fb_we !== 1'b1 || fb_addr !== 19'(200 + i) || fb_data !== 8'(8'hA0 + i))
        $display("FAIL simul_drain%0d: got we=%b addr=%0d data=%h, want 1/%0d/%h",
                 i, fb_we, fb_addr, fb_data, 200 + i, 8'(8'hA0 + i));
      else n_pass++;
    end
    fb_grant = 1'b0;
    tick();
  endtask

  task automatic test_oob();
    fb_grant = 1'b0;
    wr_en = 1'b1; wr_addr = 19'd307200; wr_data = 8'h77;
    tick();
    n_total++;
    if (pending !== 4'd0 || oob !== 1'b1)
      $display("FAIL oob_drop: got pend=%0d oob=%b, want 0/1", pending, oob);
    else n_pass++;
    wr_addr = 19'd307199; wr_data = 8'h55;
    tick();
    wr_en = 1'b0;
    n_total++;
    if (pending !== 4'd1)
      $display("FAIL oob_last_pixel: got pend=%0d, want 1", pending);
    else n_pass++;
    fb_grant = 1'b1;
    tick();
    fb_grant = 1'b0;
    n_total++;
    if (fb_we !== 1'b1 || fb_addr !== 19'd307199 || fb_data !== 8'h55 || oob !== 1'b1)
      $display("FAIL oob_emit: got we=%b addr=%0d data=%h oob=%b, want 1/307199/55/1",
               fb_we, fb_addr, fb_data, oob);
    else n_pass++;
    tick();
  endtask

  // Write on even cycles, grant on for 3 cycles then off for 3; 20 entries through 8 slots.
  task automatic test_wrap();
    int emitted = 0;
    do_reset();
    tick();
    for (int k = 0; k < 100 && emitted < 20; k++) begin
      wr_en    = (k % 2 == 0) && (k / 2 < 20);
      wr_addr  = 19'(1000 + k / 2);
      wr_data  = 8'((k / 2) * 7);
      fb_grant = (k >= 40) || ((k / 3) % 2 == 0);
      tick();
      if (fb_we) begin
        n_total++;
        if (fb_addr !== 19'(1000 + emitted) || fb_data !== 8'(emitted * 7))
          $display("FAIL wrap_order%0d: got addr=%0d data=%h, want %0d/%h",
                   emitted, fb_addr, fb_data, 1000 + emitted, 8'(emitted * 7));
        else n_pass++;
        emitted++;
      end
    end
    wr_en = 1'b0; fb_grant = 1'b0;
    n_total++;
    if (emitted != 20 || overflow !== 1'b0 || pending !== 4'd0)
      $display("FAIL wrap_total: got emitted=%0d ovf=%b pend=%0d, want 20/0/0", emitted, overflow, pending);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    fb_grant = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1; wr_addr = 19'(300 + i); wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0;
    fb_grant = 1'b1;
    tick(); tick(); tick();
    n_total++;
    if (pending !== 4'd5 || overflow !== 1'b1 || fb_we !== 1'b1)
      $display("FAIL mid_setup: got pend=%0d ovf=%b we=%b, want 5/1/1", pending, overflow, fb_we);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (pending !== 4'd0 || overflow !== 1'b0 || fb_we !== 1'b0 || stall !== 1'b0)
      $display("FAIL mid_async_clear: got pend=%0d ovf=%b we=%b stall=%b, want 0/0/0/0",
               pending, overflow, fb_we, stall);
    else n_pass++;
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (fb_we) stray++;
    end
    fb_grant = 1'b0;
    n_total++;
    if (stray != 0 || pending !== 4'd0)
      $display("FAIL mid_no_emit: got stray=%0d pend=%0d, want 0/0", stray, pending);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_simultaneous();
    test_oob();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
